multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle control sequencer. It replaces the single-cycle opcode decoder for the
//  shared-memory datapath.
//  Latches the opcode once per instruction and steps FETCH→DECODE→EXEC→MEM→WB.
//  Waits on memory handshakes and counts retired instructions.
//  Drives the same datapath control set (ALU_OP, ALU_SRC_B, REG_DST, MEM_TO_REG, ...),
//  plus PC/IR enables.
// PARAMETERS
//  OPCODE_W     4    opcode width
//  HALT_OPCODE  15   opcode value that enters HALTED
//  CNT_W        16   width of RETIRED counter (saturating)
// PORTS
//  CLK          in   1         clock; all state changes on posedge
//  RESET        in   1         synchronous, active-high
//  START        in   1         leave IDLE and begin fetching
//  INSTR_VALID  in   1         instruction word present on OPCODE (fetch done)
//  OPCODE       in   OPCODE_W  opcode field of fetched word
//  MEM_ACK      in   1         data memory completed current read/write
//  ZERO         in   1         ALU zero flag (branch condition)
//  IR_LOAD      out  1         latch instruction register
//  PC_WRITE     out  1         update PC this cycle
//  PC_SRC       out  1         1 = branch target, 0 = PC+1
//  ALU_OP       out  2         kADD / kSUB from definitions package
//  ALU_SRC_B    out  2         0 = reg, 1 = SE 3-bit imm, 2 = constant zero
//  REG_DST      out  1         destination select
//  MEM_TO_REG   out  1         1 = ALU result, 0 = memory data
//  MEM_READ     out  1         data memory read request
//  MEM_WRITE    out  1         data memory write request
//  REG_WRITE    out  1         register file write enable
//  HALT         out  1         processor halted
//  BUSY         out  1         high in every state except IDLE and HALTED
//  RETIRED      out  CNT_W     instructions completed since reset
// BEHAVIOUR
//  Clock and reset
//  - One clock (CLK). RESET is synchronous and active-high; it overrides every other input.
//  - On RESET: state=IDLE, latched opcode=0, RETIRED=0, every output 0.
//  - Reset mid-instruction abandons it; RETIRED is not incremented.
//  Output rules
//  - Outputs are decoded from state plus latched opcode (Moore).
//  - The live OPCODE input is sampled only on the IR_LOAD cycle.
//  - Outputs not listed for a state are 0.
//  Instruction classes (latched opcode)
//  - 0 LOAD:   SRC_B=2, kADD, REG_DST=1, MEM_TO_REG=0
//  - 1 ADDI:   SRC_B=1, kADD, REG_DST=0, MEM_TO_REG=1
//  - 2 STORE:  SRC_B=2, kADD
//  - 3 BRZ:    SRC_B=2, kSUB
//  - HALT_OPCODE: halt
//  - all others R-type: SRC_B=0, kADD, REG_DST=0, MEM_TO_REG=1
//  States
//  - IDLE:    START → FETCH. RESET has priority over START.
//  - FETCH:   wait for INSTR_VALID. When it is high: IR_LOAD=1, opcode latched, → DECODE.
//  - DECODE:  1 cycle. Opcode == HALT_OPCODE → HALTED, else → EXEC.
//  - EXEC:    ALU controls asserted.
//      BRZ: PC_WRITE=1, PC_SRC=ZERO, retire, → FETCH.
//      LOAD/STORE → MEM.
//      ADDI/R-type → WB.
//  - MEM:     MEM_READ (LOAD) or MEM_WRITE (STORE) held with ALU controls until MEM_ACK.
//      On ack: LOAD → WB.
//      On ack: STORE → PC_WRITE=1, retire, → FETCH.
//      MEM_ACK is ignored in every other state.
//      An ack arriving in the first MEM cycle completes that cycle, so the minimum stay is 1.
//  - WB:      REG_WRITE=1, PC_WRITE=1, class controls held, retire, → FETCH.
//  - HALTED:  HALT=1 until RESET. START, INSTR_VALID and MEM_ACK are ignored.
//      The halt instruction is not counted.
//  Latency (INSTR_VALID and MEM_ACK both immediate)
//  - BRZ 3 cycles, ADDI/R-type 4, STORE 4, LOAD 5.
//  - Each wait cycle adds 1.
//  RETIRED
//  - Increments on the retiring cycle.
//  - Saturates at 2^CNT_W-1; it does not wrap.
// STRUCTURE
//  Shared package `definitions`
//  - kADD and kSUB: already present.
//  - Add: ctrl_state_t enum {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED}.
//  - Add: opcode constants kOP_LOAD=0, kOP_ADDI=1, kOP_STORE=2, kOP_BRZ=3.
//  - Add: ctrl_bundle_t packed struct holding the datapath control fields.
//  Sub-module `control_decode`
//  - Combinational: latched opcode → ctrl_bundle_t class controls.
//  - The top level holds the state register, opcode register and RETIRED counter.
//  - It gates the bundle by state.
// TESTING
//  1. RESET high 2 cycles with START=1 → all outputs 0, state IDLE, RETIRED=0.
//  2. START, then OPCODE=1 with immediate INSTR_VALID.
//     → IR_LOAD @c1, REG_WRITE+PC_WRITE @c4, RETIRED=1.
//  3. LOAD (0), MEM_ACK delayed 3 cycles.
//     → MEM_READ high exactly 4 cycles, then WB with MEM_TO_REG=0, RETIRED+1.
//  4. BRZ (3) with ZERO=1, then with ZERO=0 → PC_SRC=1 then 0, PC_WRITE 1 cycle each.
//     REG_WRITE stays 0 throughout.
//  5. OPCODE=15 → HALT=1 from the cycle after DECODE.
//     START/MEM_ACK pulses are ignored and RETIRED is unchanged.
//     RESET clears HALT.
//  6. CNT_W=2, retire 5 ADDIs → RETIRED saturates at 3.
//     RESET asserted during MEM → IDLE next cycle and MEM_WRITE drops.

Source files
------------

// File: rtl/definitions.sv
// Shared datapath definitions: ALU op codes, opcode constants, sequencer states
// and the bundle of class controls produced by the opcode decoder.
package definitions;

  localparam logic [1:0] kADD = 2'd0;
  localparam logic [1:0] kSUB = 2'd1;

  localparam int kOP_LOAD  = 0;
  localparam int kOP_ADDI  = 1;
  localparam int kOP_STORE = 2;
  localparam int kOP_BRZ   = 3;

  localparam logic [1:0] kSRC_REG  = 2'd0;
  localparam logic [1:0] kSRC_IMM  = 2'd1;
  localparam logic [1:0] kSRC_ZERO = 2'd2;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_LOAD, CLS_ADDI, CLS_STORE, CLS_BRZ, CLS_HALT
  } instr_class_t;

  typedef struct packed {
    instr_class_t kind;
    logic [1:0]   alu_op;
    logic [1:0]   alu_src_b;
    logic         reg_dst;
    logic         mem_to_reg;
  } ctrl_bundle_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: maps the latched opcode to its instruction class
// and the class-level datapath controls; the sequencer gates these by state.
module control_decode
  import definitions::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int HALT_OPCODE = 15
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_bundle_t        ctrl
);

  // Halt is tested first so a halt code can never alias a memory or branch class.
  always_comb begin
    ctrl            = '0;
    ctrl.kind       = CLS_RTYPE;
    ctrl.alu_op     = kADD;
    ctrl.alu_src_b  = kSRC_REG;
    ctrl.mem_to_reg = 1'b1;
    if (opcode == OPCODE_W'(HALT_OPCODE)) begin
      ctrl.kind       = CLS_HALT;
      ctrl.mem_to_reg = 1'b0;
    end else if (opcode == OPCODE_W'(kOP_LOAD)) begin
      ctrl.kind       = CLS_LOAD;
      ctrl.alu_src_b  = kSRC_ZERO;
      ctrl.reg_dst    = 1'b1;
      ctrl.mem_to_reg = 1'b0;
    end else if (opcode == OPCODE_W'(kOP_ADDI)) begin
      ctrl.kind      = CLS_ADDI;
      ctrl.alu_src_b = kSRC_IMM;
    end else if (opcode == OPCODE_W'(kOP_STORE)) begin
      ctrl.kind       = CLS_STORE;
      ctrl.alu_src_b  = kSRC_ZERO;
      ctrl.mem_to_reg = 1'b0;
    end else if (opcode == OPCODE_W'(kOP_BRZ)) begin
      ctrl.kind       = CLS_BRZ;
      ctrl.alu_op     = kSUB;
      ctrl.alu_src_b  = kSRC_ZERO;
      ctrl.mem_to_reg = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the shared-memory datapath: steps
// FETCH/DECODE/EXEC/MEM/WB per instruction and counts retired instructions.
module multicycle_control
  import definitions::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int HALT_OPCODE = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ack,
  input  logic                zero,
  output logic                ir_load,
  output logic                pc_write,
  output logic                pc_src,
  output logic [1:0]          alu_op,
  output logic [1:0]          alu_src_b,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                halt,
  output logic                busy,
  output logic [CNT_W-1:0]    retired
);

  ctrl_state_t         state;
  logic [OPCODE_W-1:0] op_q;
  ctrl_bundle_t        cls;
  logic                retire;

  control_decode #(
    .OPCODE_W    (OPCODE_W),
    .HALT_OPCODE (HALT_OPCODE)
  ) u_decode (
    .opcode (op_q),
    .ctrl   (cls)
  );

  always_comb begin
    retire = ((state == EXEC) && (cls.kind == CLS_BRZ))
          || ((state == MEM) && mem_ack && (cls.kind == CLS_STORE))
          || (state == WB);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      retired <= '0;
    end else begin
      if (retire && (retired != '1))
        retired <= retired + CNT_W'(1);
      case (state)
        IDLE:   if (start) state <= FETCH;
        FETCH:  if (instr_valid) begin
                  op_q  <= opcode;
                  state <= DECODE;
                end
        DECODE: state <= (cls.kind == CLS_HALT) ? HALTED : EXEC;
        EXEC: begin
          case (cls.kind)
            CLS_BRZ:             state <= FETCH;
            CLS_LOAD, CLS_STORE: state <= MEM;
            default:             state <= WB;
          endcase
        end
        MEM:    if (mem_ack) state <= (cls.kind == CLS_LOAD) ? WB : FETCH;
        WB:     state <= FETCH;
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of state plus latched class; only the fetch, branch and
  // memory-ack cycles look at live handshake inputs. Reset forces all quiet.
  always_comb begin
    // NOTE: every output is given a default before any branch so no path
    // through this block can infer a latch.
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_op     = '0;
    alu_src_b  = '0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    halt       = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      busy = (state != IDLE) && (state != HALTED);
      if ((state == EXEC) || (state == MEM) || (state == WB)) begin
        alu_op     = cls.alu_op;
        alu_src_b  = cls.alu_src_b;
        reg_dst    = cls.reg_dst;
        mem_to_reg = cls.mem_to_reg;
      end
      case (state)
        FETCH: ir_load = instr_valid;
        EXEC: if (cls.kind == CLS_BRZ) begin
          pc_write = 1'b1;
          pc_src   = zero;
        end
        MEM: begin
          mem_read  = (cls.kind == CLS_LOAD);
          mem_write = (cls.kind == CLS_STORE);
          pc_write  = mem_ack && (cls.kind == CLS_STORE);
        end
        WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        HALTED: halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
